readout_seq_ctrl: RTL and testbench
===================================

READOUT_SEQ_CTRL -- requirements
Module: readout_seq_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 48; words per frame, legal range 3..63.
REQ-002 SHALL have parameter TIMEOUT, default 1023; idle cycles before a dummy frame is forced; used only under REQ-030.
REQ-003 SHALL have port CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous active-low reset.
REQ-005 SHALL have port RUN_EN  in  1  level; 1 = sequencing enabled.
REQ-006 SHALL have port SR_OUT_IN  in  1  single-cycle start-of-frame strobe from the ASIC shift register.
REQ-007 SHALL have port RD_DONE  in  1  single-cycle pulse; the consumer has finished reading bank RD_BANK.
REQ-008 SHALL have port RD_BANK  in  1  bank index qualified by RD_DONE.
REQ-009 SHALL have port CH_ID  out  2  word select to the framer: 00 idle, 01 header, 10 data, 11 footer.
REQ-010 SHALL have port WR_BANK  out  1  ping-pong bank currently being written.
REQ-011 SHALL have port BANK_FULL  out  2  per-bank full flags; bit n = bank n holds a complete frame.
REQ-012 SHALL have port FRAME_CNT  out  16  count of frames committed to a bank.
REQ-013 SHALL have port OVERFLOW  out  1  sticky; a frame was dropped because both banks were full.
REQ-014 SHALL have port BUSY  out  1  1 while in HEADER, DATA or FOOTER.

Function
REQ-015 SHALL implement the states IDLE, WAIT_SOF, HEADER, DATA, FOOTER, SWAP and DROP, with registered outputs.
REQ-016 SHALL, in IDLE, go to WAIT_SOF when RUN_EN=1.
REQ-017 SHALL, in WAIT_SOF, go to HEADER on SR_OUT_IN=1 if BANK_FULL[WR_BANK]=0, otherwise go to DROP and set OVERFLOW.
REQ-018 SHALL hold HEADER for 1 cycle, DATA for FRAME_LEN-2 cycles (6-bit slot counter from 1), and FOOTER for 1 cycle.
REQ-019 SHALL drive CH_ID one cycle after the state it reflects, and drive 00 in IDLE, WAIT_SOF, SWAP and DROP.
REQ-020 SHALL, in SWAP (1 cycle), set BANK_FULL[WR_BANK], increment FRAME_CNT (wrapping 0xFFFF->0), toggle WR_BANK, then return to WAIT_SOF, or to IDLE if RUN_EN=0.
REQ-021 SHALL hold DROP for FRAME_LEN cycles with no writes and no count, then return to WAIT_SOF.
REQ-022 SHALL ignore SR_OUT_IN while in HEADER, DATA, FOOTER, SWAP or DROP.
REQ-023 SHALL let a frame in progress finish through SWAP when RUN_EN falls mid-frame.
REQ-024 SHALL clear BANK_FULL[RD_BANK] on RD_DONE, and RD_DONE for a bank that is not full SHALL have no effect.
REQ-025 SHALL, when RD_DONE clears a bank in the same cycle SWAP sets the other bank, apply both; if both target the same bank, the set wins.
REQ-026 SHALL clear OVERFLOW only by reset, or by a RUN_EN rising edge.

Reset
REQ-027 SHALL, on RST=0 and asynchronously, force state IDLE, CH_ID=00, WR_BANK=0, BANK_FULL=00, FRAME_CNT=0, OVERFLOW=0, BUSY=0, and slot counter 0.
REQ-028 SHALL, on reset mid-frame, abandon the frame with no bank marked full.
REQ-029 SHALL leave IDLE no earlier than the first clock edge after RST returns to 1.

Configuration
REQ-030 SHALL, with SEQ_SOF_TIMEOUT_EN defined, start a dummy frame (HEADER onward, subject to the same bank-full rule) after TIMEOUT consecutive cycles in WAIT_SOF without SR_OUT_IN.
REQ-031 SHALL, without SEQ_SOF_TIMEOUT_EN, contain no timeout counter and wait in WAIT_SOF indefinitely.

Verification
REQ-032 SHALL cover: RUN_EN=1, SR_OUT_IN pulse -> CH_ID shows 01 for 1 cycle, then 10 for 46 cycles, then 11 for 1 cycle; BANK_FULL=01; WR_BANK=1; FRAME_CNT=1.
REQ-033 SHALL cover: three SOFs with no RD_DONE -> frames 1 and 2 are committed (BANK_FULL=11); the third goes to DROP, OVERFLOW=1, FRAME_CNT stays 2.
REQ-034 SHALL cover: RD_DONE with RD_BANK=0 in the same cycle as SWAP of bank 1 -> BANK_FULL goes from 01 to 10.
REQ-035 SHALL cover: RST asserted at DATA slot 20 -> all outputs at reset values immediately, BANK_FULL=00, and no footer emitted.
REQ-036 SHALL cover: RUN_EN dropped at DATA slot 10 -> the frame completes (footer, SWAP), then IDLE; a later SOF is ignored.
REQ-037 SHALL cover: with SEQ_SOF_TIMEOUT_EN, TIMEOUT=15 and no SOF -> HEADER is entered 15 cycles after entering WAIT_SOF; without the macro, no frame occurs.

Source files
------------

// File: rtl/readout_seq_ctrl.sv
// Ping-pong readout frame sequencer: header/data/footer word select, bank tracking, drop on overflow.
// Optional SOF timeout (dummy frame after TIMEOUT idle cycles) enabled by defining SEQ_SOF_TIMEOUT_EN.
module readout_seq_ctrl #(
  parameter int FRAME_LEN = 48,
  parameter int TIMEOUT   = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN_EN,
  input  logic        SR_OUT_IN,
  input  logic        RD_DONE,
  input  logic        RD_BANK,
  output logic [1:0]  CH_ID,
  output logic        WR_BANK,
  output logic [1:0]  BANK_FULL,
  output logic [15:0] FRAME_CNT,
  output logic        OVERFLOW,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE, WAIT_SOF, HEADER, DATA, FOOTER, SWAP, DROP
  } state_t;

  localparam logic [5:0] LAST_SLOT = 6'(FRAME_LEN - 2);
  localparam logic [5:0] DROP_LAST = 6'(FRAME_LEN);

  if (FRAME_LEN < 3 || FRAME_LEN > 63 || TIMEOUT < 1) begin : g_bad_param
    $error("readout_seq_ctrl: FRAME_LEN must be 3..63 and TIMEOUT >= 1");
  end

  state_t      state_q, state_d;
  logic [5:0]  slot_q, slot_d;
  logic [1:0]  ch_id_q, ch_id_d;
  logic        wr_bank_q, wr_bank_d;
  logic [1:0]  bank_full_q, bank_full_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic        run_en_prev_q, run_en_prev_d;
  logic        start_frame;

`ifdef SEQ_SOF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    wr_bank_d     = wr_bank_q;
    bank_full_d   = bank_full_q;
    frame_cnt_d   = frame_cnt_q;
    overflow_d    = overflow_q;
    run_en_prev_d = RUN_EN;
`ifdef SEQ_SOF_TIMEOUT_EN
    to_cnt_d      = '0;
    start_frame   = SR_OUT_IN || (to_cnt_q == TW'(TIMEOUT - 1));
`else
    start_frame   = SR_OUT_IN;
`endif

    if (RUN_EN && !run_en_prev_q) overflow_d = 1'b0;
    if (RD_DONE) bank_full_d[RD_BANK] = 1'b0;

    // CH_ID lags the state by one cycle
    unique case (state_q)
      HEADER:  ch_id_d = 2'b01;
      DATA:    ch_id_d = 2'b10;
      FOOTER:  ch_id_d = 2'b11;
      default: ch_id_d = 2'b00;
    endcase

    unique case (state_q)
      IDLE: if (RUN_EN) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (!RUN_EN) begin
          state_d = IDLE;
        end else if (start_frame) begin
          if (bank_full_q[wr_bank_q]) begin
            state_d    = DROP;
            overflow_d = 1'b1;
            slot_d     = 6'd1;
          end else begin
            state_d = HEADER;
          end
        end else begin
`ifdef SEQ_SOF_TIMEOUT_EN
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      HEADER: begin
        state_d = DATA;
        slot_d  = 6'd1;
      end
      DATA: begin
        if (slot_q == LAST_SLOT) begin
          state_d = FOOTER;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 6'd1;
        end
      end
      FOOTER: state_d = SWAP;
      SWAP: begin
        // applied after the RD_DONE clear so a same-bank set wins
        bank_full_d[wr_bank_q] = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        wr_bank_d   = ~wr_bank_q;
        state_d     = RUN_EN ? WAIT_SOF : IDLE;
      end
      DROP: begin
        if (slot_q == DROP_LAST) begin
          state_d = WAIT_SOF;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == HEADER) || (state_d == DATA) || (state_d == FOOTER);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      ch_id_q       <= '0;
      wr_bank_q     <= 1'b0;
      bank_full_q   <= '0;
      frame_cnt_q   <= '0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      run_en_prev_q <= 1'b0;
`ifdef SEQ_SOF_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      ch_id_q       <= ch_id_d;
      wr_bank_q     <= wr_bank_d;
      bank_full_q   <= bank_full_d;
      frame_cnt_q   <= frame_cnt_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      run_en_prev_q <= run_en_prev_d;
`ifdef SEQ_SOF_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign CH_ID     = ch_id_q;
  assign WR_BANK   = wr_bank_q;
  assign BANK_FULL = bank_full_q;
  assign FRAME_CNT = frame_cnt_q;
  assign OVERFLOW  = overflow_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_readout_seq_ctrl.sv
// Directed bench for readout_seq_ctrl (FRAME_LEN=48, TIMEOUT=15); expected values hand-derived.
module tb_readout_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST, RUN_EN, SR_OUT_IN, RD_DONE, RD_BANK;
  logic [1:0]  CH_ID, BANK_FULL;
  logic        WR_BANK, OVERFLOW, BUSY;
  logic [15:0] FRAME_CNT;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        flag;

  readout_seq_ctrl #(.FRAME_LEN(48), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .RUN_EN(RUN_EN), .SR_OUT_IN(SR_OUT_IN),
    .RD_DONE(RD_DONE), .RD_BANK(RD_BANK), .CH_ID(CH_ID), .WR_BANK(WR_BANK),
    .BANK_FULL(BANK_FULL), .FRAME_CNT(FRAME_CNT), .OVERFLOW(OVERFLOW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sof_pulse();
    SR_OUT_IN = 1'b1;
    step();
    SR_OUT_IN = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    step(2);
    RST = 1'b1;
  endtask

  task automatic swap_with_rd(input logic bank);
    RD_DONE = 1'b1;
    RD_BANK = bank;
    step();
    RD_DONE = 1'b0;
  endtask

  initial begin
    RST = 1'b0; RUN_EN = 1'b0; SR_OUT_IN = 1'b0; RD_DONE = 1'b0; RD_BANK = 1'b0;
    #1;
    check("rst_ch_id", 16'(CH_ID), 16'h0);
    check("rst_wr_bank", 16'(WR_BANK), 16'h0);
    check("rst_bank_full", 16'(BANK_FULL), 16'h0);
    check("rst_frame_cnt", FRAME_CNT, 16'h0);
    check("rst_overflow", 16'(OVERFLOW), 16'h0);
    check("rst_busy", 16'(BUSY), 16'h0);
    step(2);
    RST = 1'b1;
    step(2);

    // single frame: 01 x1, 10 x46, 11 x1
    RUN_EN = 1'b1;
    step();
    sof_pulse();
    check("hdr_busy", 16'(BUSY), 16'h1);
    check("hdr_ch_lag", 16'(CH_ID), 16'h0);
    step();
    check("f1_header", 16'(CH_ID), 16'h1);
    for (int i = 0; i < 46; i++) begin
      step();
      check($sformatf("f1_data%0d", i + 1), 16'(CH_ID), 16'h2);
    end
    step();
    check("f1_footer", 16'(CH_ID), 16'h3);
    step();
    check("f1_ch_idle", 16'(CH_ID), 16'h0);
    check("f1_bank_full", 16'(BANK_FULL), 16'h1);
    check("f1_wr_bank", 16'(WR_BANK), 16'h1);
    check("f1_frame_cnt", FRAME_CNT, 16'd1);
    check("f1_busy", 16'(BUSY), 16'h0);

    // second frame fills bank 1, third is dropped
    sof_pulse();
    step(49);
    check("f2_bank_full", 16'(BANK_FULL), 16'h3);
    check("f2_wr_bank", 16'(WR_BANK), 16'h0);
    check("f2_frame_cnt", FRAME_CNT, 16'd2);
    sof_pulse();
    check("drop_overflow", 16'(OVERFLOW), 16'h1);
    check("drop_busy", 16'(BUSY), 16'h0);
    step(10);
    sof_pulse();
    step(37);
    check("drop_busy_end", 16'(BUSY), 16'h0);
    check("drop_frame_cnt", FRAME_CNT, 16'd2);
    check("drop_bank_full", 16'(BANK_FULL), 16'h3);
    RUN_EN = 1'b0;
    step();
    check("ovf_sticky", 16'(OVERFLOW), 16'h1);
    RUN_EN = 1'b1;
    step();
    check("ovf_clr_rise", 16'(OVERFLOW), 16'h0);

    // RD_DONE on bank 0 coincident with SWAP of bank 1
    do_reset();
    step();
    sof_pulse();
    step(49);
    check("rd_pre_full", 16'(BANK_FULL), 16'h1);
    sof_pulse();
    step(48);
    check("rd_swap_ch", 16'(CH_ID), 16'h3);
    check("rd_before_swap", 16'(BANK_FULL), 16'h1);
    swap_with_rd(1'b0);
    check("rd_swap_both", 16'(BANK_FULL), 16'h2);
    check("rd_swap_cnt", FRAME_CNT, 16'd2);
    check("rd_swap_wr", 16'(WR_BANK), 16'h0);
    swap_with_rd(1'b0);
    check("rd_not_full", 16'(BANK_FULL), 16'h2);
    sof_pulse();
    step(48);
    swap_with_rd(1'b0);
    check("rd_set_wins", 16'(BANK_FULL), 16'h3);
    check("rd_set_cnt", FRAME_CNT, 16'd3);

    // reset mid-frame at DATA slot 20
    do_reset();
    step();
    sof_pulse();
    step(20);
    check("mid_ch_data", 16'(CH_ID), 16'h2);
    check("mid_busy", 16'(BUSY), 16'h1);
    RST = 1'b0;
    #1;
    check("mid_rst_ch", 16'(CH_ID), 16'h0);
    check("mid_rst_busy", 16'(BUSY), 16'h0);
    check("mid_rst_full", 16'(BANK_FULL), 16'h0);
    check("mid_rst_wr", 16'(WR_BANK), 16'h0);
    check("mid_rst_cnt", FRAME_CNT, 16'h0);
    RUN_EN = 1'b0;
    step(3);
    RST = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (CH_ID != 2'b00 || BUSY) flag = 1'b1;
    end
    check("mid_no_footer", 16'(flag), 16'h0);
    check("mid_full_after", 16'(BANK_FULL), 16'h0);

    // RUN_EN dropped at DATA slot 10
    RUN_EN = 1'b1;
    step();
    sof_pulse();
    step(10);
    RUN_EN = 1'b0;
    step(38);
    check("stop_footer", 16'(CH_ID), 16'h3);
    step();
    check("stop_full", 16'(BANK_FULL), 16'h1);
    check("stop_cnt", FRAME_CNT, 16'd1);
    check("stop_wr", 16'(WR_BANK), 16'h1);
    sof_pulse();
    flag = BUSY;
    for (int i = 0; i < 55; i++) begin
      step();
      if (BUSY || CH_ID != 2'b00) flag = 1'b1;
    end
    check("stop_sof_ignored", 16'(flag), 16'h0);
    check("stop_cnt_after", FRAME_CNT, 16'd1);

    // SOF timeout behaviour
    RUN_EN = 1'b1;
    step();
`ifdef SEQ_SOF_TIMEOUT_EN
    flag = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (BUSY) flag = 1'b1;
    end
    check("to_early", 16'(flag), 16'h0);
    step();
    check("to_header", 16'(BUSY), 16'h1);
`else
    flag = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (BUSY) flag = 1'b1;
    end
    check("to_none", 16'(flag), 16'h0);
    check("to_none_cnt", FRAME_CNT, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
